i2c_bus_arbiter: RTL and testbench

- Shares one i2c_controller master between NUM_REQ client blocks, such as sensor pollers and config loaders, using round-robin arbitration.
- Sequences each granted transaction through the master's enable/ready handshake and returns read data plus a status to the winning client.
- Adds a watchdog so that a master which never starts or never finishes cannot hang the bus.
- Sits between the client blocks and the i2c_controller instance; all logic runs on the system clock.

---
 rtl/i2c_bus_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_bus_arbiter
//  Purpose  : Round-robin sharing of one i2c_controller master between
//             NUM_REQ clients, with an enable/ready handshake and a watchdog.
//  Revision : 1.0  initial release
// ============================================================================
module i2c_bus_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [7*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_wdata,
    input  logic [NUM_REQ-1:0]     req_rw,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic [7:0]             rdata,
    output logic                   err,
    output logic                   busy,
    output logic [6:0]             m_addr,
    output logic [7:0]             m_data,
    output logic                   m_rw,
    output logic                   m_enable,
    input  logic                   m_ready,
    input  logic [7:0]             m_rdata
);

    localparam int c_ptr_w = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int c_tmr_w = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_COMPLETE  = 2'd3
    } state_t;

    state_t                 r_state_q, w_state_d;
    logic [c_ptr_w-1:0]     r_ptr_q,   w_ptr_d;
    logic [c_tmr_w-1:0]     r_tmr_q,   w_tmr_d;
    logic [SYNC_STAGES-1:0] r_sync_q,  w_sync_d;
    logic [NUM_REQ-1:0]     r_gnt_q,   w_gnt_d;
    logic [NUM_REQ-1:0]     r_done_q,  w_done_d;
    logic [7:0]             r_rdata_q, w_rdata_d;
    logic                   r_err_q,   w_err_d;
    logic                   r_busy_q,  w_busy_d;
    logic [6:0]             r_addr_q,  w_addr_d;
    logic [7:0]             r_data_q,  w_data_d;
    logic                   r_rw_q,    w_rw_d;
    logic                   r_en_q,    w_en_d;

    logic                   w_rdy_s;
    logic [NUM_REQ-1:0]     w_rot;
    logic                   w_found;
    int                     w_off;
    int                     w_sum;
    logic [c_ptr_w-1:0]     w_win;
    logic [c_ptr_w-1:0]     w_next_ptr;

    // m_ready comes from the master's divided-clock domain
    assign w_sync_d = SYNC_STAGES'({r_sync_q, m_ready});
    assign w_rdy_s  = r_sync_q[SYNC_STAGES-1];

    // Rotate requests so the search always starts at bit 0, then map back
    always_comb begin
        w_rot   = NUM_REQ'({req, req} >> r_ptr_q);
        w_found = 1'b0;
        w_off   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_off   = i;
            end
        end
        w_sum = int'(r_ptr_q) + w_off;
        if (w_sum >= NUM_REQ) begin
            w_sum = w_sum - NUM_REQ;
        end
        w_win      = c_ptr_w'(w_sum);
        w_next_ptr = (w_win == c_ptr_last) ? '0 : w_win + 1'b1;
    end

    always_comb begin
        w_state_d = r_state_q;
        w_ptr_d   = r_ptr_q;
        w_tmr_d   = r_tmr_q;
        w_gnt_d   = r_gnt_q;
        w_done_d  = '0;
        w_rdata_d = r_rdata_q;
        w_err_d   = r_err_q;
        w_addr_d  = r_addr_q;
        w_data_d  = r_data_q;
        w_rw_d    = r_rw_q;
        w_en_d    = r_en_q;

        case (r_state_q)
            S_IDLE: begin
                if (w_found && w_rdy_s) begin
                    w_state_d = S_LAUNCH;
                    w_gnt_d   = NUM_REQ'(1) << w_win;
                    w_ptr_d   = w_next_ptr;
                    w_addr_d  = req_addr[7*w_sum +: 7];
                    w_data_d  = req_wdata[8*w_sum +: 8];
                    w_rw_d    = req_rw[w_sum];
                    w_en_d    = 1'b1;
                    w_tmr_d   = '0;
                end
            end
            S_LAUNCH: begin
                if (!w_rdy_s) begin
                    w_state_d = S_WAIT_DONE;
                    w_en_d    = 1'b0;
                    w_tmr_d   = '0;
                end else if (r_tmr_q == c_tmr_last) begin
                    w_state_d = S_COMPLETE;
                    w_en_d    = 1'b0;
                    w_err_d   = 1'b1;
                    w_rdata_d = '0;
                    w_done_d  = r_gnt_q;
                end else begin
                    w_tmr_d = r_tmr_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                w_en_d = 1'b0;
                if (w_rdy_s) begin
                    w_state_d = S_COMPLETE;
                    w_rdata_d = m_rdata;
                    w_err_d   = 1'b0;
                    w_done_d  = r_gnt_q;
                end else if (r_tmr_q == c_tmr_last) begin
                    w_state_d = S_COMPLETE;
                    w_err_d   = 1'b1;
                    w_rdata_d = '0;
                    w_done_d  = r_gnt_q;
                end else begin
                    w_tmr_d = r_tmr_q + 1'b1;
                end
            end
            S_COMPLETE: begin
                w_state_d = S_IDLE;
                w_gnt_d   = '0;
            end
            default: begin
                w_state_d = S_IDLE;
                w_gnt_d   = '0;
                w_en_d    = 1'b0;
            end
        endcase

        w_busy_d = (w_state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q <= S_IDLE;
            r_ptr_q   <= '0;
            r_tmr_q   <= '0;
            r_sync_q  <= '0;
            r_gnt_q   <= '0;
            r_done_q  <= '0;
            r_rdata_q <= '0;
            r_err_q   <= 1'b0;
            r_busy_q  <= 1'b0;
            r_addr_q  <= '0;
            r_data_q  <= '0;
            r_rw_q    <= 1'b0;
            r_en_q    <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_ptr_q   <= w_ptr_d;
            r_tmr_q   <= w_tmr_d;
            r_sync_q  <= w_sync_d;
            r_gnt_q   <= w_gnt_d;
            r_done_q  <= w_done_d;
            r_rdata_q <= w_rdata_d;
            r_err_q   <= w_err_d;
            r_busy_q  <= w_busy_d;
            r_addr_q  <= w_addr_d;
            r_data_q  <= w_data_d;
            r_rw_q    <= w_rw_d;
            r_en_q    <= w_en_d;
        end
    end

    assign gnt      = r_gnt_q;
    assign done     = r_done_q;
    assign rdata    = r_rdata_q;
    assign err      = r_err_q;
    assign busy     = r_busy_q;
    assign m_addr   = r_addr_q;
    assign m_data   = r_data_q;
    assign m_rw     = r_rw_q;
    assign m_enable = r_en_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_bus_arbiter
//  Purpose  : Self-checking bench for i2c_bus_arbiter with a behavioural
//             master/slave model and a round-robin reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_i2c_bus_arbiter;

    localparam int N    = 4;
    localparam int TOUT = 1000;
    localparam int SYNC = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [7*N-1:0] req_addr = '0;
    logic [8*N-1:0] req_wdata = '0;
    logic [N-1:0]   req_rw = '0;
    logic [N-1:0]   gnt, done;
    logic [7:0]     rdata;
    logic           err, busy;
    logic [6:0]     m_addr;
    logic [7:0]     m_data;
    logic           m_rw, m_enable;
    logic           m_ready = 1'b1;
    logic [7:0]     m_rdata = 8'h00;

    int tests = 0;
    int fails = 0;
    int mptr  = 0;

    // Slave contents and master model state
    logic [7:0] slave_mem [128];
    bit         slave_nack [128];
    bit         m_stuck = 1'b0;
    bit         m_busy_t = 1'b0;
    int         m_cnt = 0;
    int         m_starts = 0;
    logic [6:0] m_cur_addr = '0;
    logic       m_cur_rw = 1'b0;

    always #5 clk = ~clk;

    i2c_bus_arbiter #(
        .NUM_REQ(N), .TIMEOUT_CYCLES(TOUT), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rw(req_rw), .gnt(gnt), .done(done),
        .rdata(rdata), .err(err), .busy(busy), .m_addr(m_addr),
        .m_data(m_data), .m_rw(m_rw), .m_enable(m_enable),
        .m_ready(m_ready), .m_rdata(m_rdata)
    );

    // Master: leaves IDLE the edge after it sees enable, runs a few cycles, returns
    always @(posedge clk) begin
        if (m_busy_t) begin
            if (m_cnt == 0) begin
                m_busy_t <= 1'b0;
                m_ready  <= 1'b1;
                if (m_cur_rw && !slave_nack[m_cur_addr]) m_rdata <= slave_mem[m_cur_addr];
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (m_enable && !m_stuck) begin
            m_busy_t   <= 1'b1;
            m_ready    <= 1'b0;
            m_cur_addr <= m_addr;
            m_cur_rw   <= m_rw;
            m_starts   <= m_starts + 1;
            m_cnt      <= slave_nack[m_addr] ? 5 : int'($urandom_range(20, 8));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_client(input int i, input logic [6:0] a, input logic [7:0] d, input logic rw);
        req_addr[7*i +: 7]  = a;
        req_wdata[8*i +: 8] = d;
        req_rw[i]           = rw;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = '0;
        repeat (3) tick();
        tests++; if ({gnt, done} !== '0) begin fails++; $display("FAIL rst_gnt_done got %b want 0", {gnt, done}); end
        tests++; if ({rdata, err, busy} !== '0) begin fails++; $display("FAIL rst_rdata_err_busy got %h want 0", {rdata, err, busy}); end
        tests++; if ({m_addr, m_data, m_rw, m_enable} !== '0) begin fails++; $display("FAIL rst_master got %h want 0", {m_addr, m_data, m_rw, m_enable}); end
        rst = 1'b1;
        repeat (4) tick();
        mptr = 0;
    endtask

    task automatic test_single_write();
        int  starts0, en_cycles;
        bit  seen;
        starts0 = m_starts;
        set_client(2, 7'h48, 8'hA5, 1'b0);
        req = 4'b0100;
        tick();
        tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL wr_gnt got %b want 0100", gnt); end
        tests++; if ({m_enable, m_addr, m_data, m_rw} !== {1'b1, 7'h48, 8'hA5, 1'b0}) begin fails++; $display("FAIL wr_fields got %b %h %h %b want 1 48 a5 0", m_enable, m_addr, m_data, m_rw); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL wr_busy got %b want 1", busy); end
        mptr = 3;
        en_cycles = 1;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            tick();
            if (m_enable) en_cycles++;
            if (done != '0) begin
                seen = 1'b1;
                tests++; if ({done, err, m_enable, m_ready} !== {4'b0100, 1'b0, 1'b0, 1'b1}) begin fails++; $display("FAIL wr_done got done=%b err=%b en=%b rdy=%b want 0100 0 0 1", done, err, m_enable, m_ready); end
            end
        end
        tests++; if (!seen) begin fails++; $display("FAIL wr_done_timeout got none want pulse"); end
        tests++; if (en_cycles != SYNC + 2) begin fails++; $display("FAIL wr_en_len got %0d want %0d", en_cycles, SYNC + 2); end
        req = '0;
        tick();
        tests++; if ({busy, gnt, done} !== '0) begin fails++; $display("FAIL wr_after got busy=%b gnt=%b done=%b want 0", busy, gnt, done); end
        tests++; if (m_starts - starts0 != 1) begin fails++; $display("FAIL wr_starts got %0d want 1", m_starts - starts0); end
    endtask

    task automatic test_read();
        bit seen;
        slave_mem[7'h1D] = 8'h3C;
        set_client(0, 7'h1D, 8'h00, 1'b1);
        req = 4'b0001;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            tick();
            if (done != '0) begin
                seen = 1'b1;
                tests++; if ({done, rdata, err} !== {4'b0001, 8'h3C, 1'b0}) begin fails++; $display("FAIL rd_done got done=%b rdata=%h err=%b want 0001 3c 0", done, rdata, err); end
            end
        end
        tests++; if (!seen) begin fails++; $display("FAIL rd_timeout got none want pulse"); end
        mptr = 1;
        req = '0;
        tick();
    endtask

    task automatic test_contention();
        logic [N-1:0] masks [12];
        logic [N-1:0] pending, prev_gnt;
        int exp, cur, guard, order;
        masks[0] = 4'b1011; masks[1] = 4'b1111; masks[2] = 4'b0001; masks[3] = 4'b1111;
        for (int r = 4; r < 12; r++) masks[r] = N'($urandom_range(15, 1));
        rst = 1'b0; tick(); tick(); rst = 1'b1;
        repeat (4) tick();
        mptr = 0;
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < N; i++)
                set_client(i, 7'($urandom), 8'($urandom), 1'($urandom));
            pending = masks[r];
            req = masks[r];
            prev_gnt = '0;
            guard = 0;
            cur = 0;
            order = 0;
            while (pending != '0 && guard < 400) begin
                tick();
                guard++;
                if (gnt != '0 && prev_gnt == '0) begin
                    exp = -1;
                    for (int k = 0; k < N; k++)
                        if (exp < 0 && pending[(mptr + k) % N]) exp = (mptr + k) % N;
                    cur = exp;
                    for (int k = 0; k < N; k++) if (gnt[k]) order = order * 16 + k + 1;
                    tests++; if (gnt !== N'(1 << exp)) begin fails++; $display("FAIL rr_gnt round %0d got %b want %b", r, gnt, N'(1 << exp)); end
                    tests++; if ({m_addr, m_data, m_rw} !== {req_addr[7*exp +: 7], req_wdata[8*exp +: 8], req_rw[exp]}) begin fails++; $display("FAIL rr_fields round %0d got %h %h %b", r, m_addr, m_data, m_rw); end
                    mptr = (exp + 1) % N;
                end
                if (done != '0) begin
                    tests++; if ({done, err} !== {N'(1 << cur), 1'b0}) begin fails++; $display("FAIL rr_done round %0d got %b err=%b want %b 0", r, done, err, N'(1 << cur)); end
                    if (req_rw[cur]) begin
                        tests++; if (rdata !== slave_mem[req_addr[7*cur +: 7]]) begin fails++; $display("FAIL rr_rdata round %0d got %h want %h", r, rdata, slave_mem[req_addr[7*cur +: 7]]); end
                    end
                    pending[cur] = 1'b0;
                    req[cur] = 1'b0;
                end
                prev_gnt = gnt;
            end
            tests++; if (pending != '0) begin fails++; $display("FAIL rr_hang round %0d got pending %b want 0", r, pending); end
            if (r == 0) begin tests++; if (order != 'h124) begin fails++; $display("FAIL rr_order0 got %h want 124", order); end end
            if (r == 1) begin tests++; if (order != 'h1234) begin fails++; $display("FAIL rr_order1 got %h want 1234", order); end end
            if (r == 3) begin tests++; if (order != 'h2341) begin fails++; $display("FAIL rr_order3 got %h want 2341", order); end end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int ndone;
        set_client(1, 7'h2A, 8'h5A, 1'b0);
        req = 4'b0010;
        ndone = 0;
        for (int c = 0; c < 300 && ndone < 3; c++) begin
            tick();
            if (done != '0) begin
                ndone++;
                if (ndone == 3) req = '0;
                tick();
                tests++; if ({busy, gnt} !== '0) begin fails++; $display("FAIL b2b_gap got busy=%b gnt=%b want 0", busy, gnt); end
                tick();
                tests++; if (gnt !== ((ndone < 3) ? 4'b0010 : 4'b0000)) begin fails++; $display("FAIL b2b_regrant %0d got %b", ndone, gnt); end
            end
        end
        tests++; if (ndone != 3) begin fails++; $display("FAIL b2b_count got %0d want 3", ndone); end
        mptr = 2;
        tick();
    endtask

    task automatic test_nack();
        bit seen;
        int starts0;
        starts0 = m_starts;
        slave_nack[7'h50] = 1'b1;
        set_client(3, 7'h50, 8'h11, 1'b0);
        req = 4'b1000;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            tick();
            if (done != '0) begin
                seen = 1'b1;
                tests++; if ({done, err} !== {4'b1000, 1'b0}) begin fails++; $display("FAIL nack_done got %b err=%b want 1000 0", done, err); end
            end
        end
        tests++; if (!seen || m_starts - starts0 != 1) begin fails++; $display("FAIL nack_hang got seen=%b starts=%0d want 1 1", seen, m_starts - starts0); end
        req = '0;
        tick();
    endtask

    task automatic test_timeout();
        bit seen;
        int en_cnt;
        m_stuck = 1'b1;
        set_client(1, 7'h22, 8'h00, 1'b1);
        req = 4'b0010;
        tick();
        tests++; if ({gnt, m_enable} !== {4'b0010, 1'b1}) begin fails++; $display("FAIL to_start got %b %b want 0010 1", gnt, m_enable); end
        en_cnt = 1;
        seen = 1'b0;
        for (int c = 0; c < 1200 && !seen; c++) begin
            tick();
            if (done != '0) begin
                seen = 1'b1;
                tests++; if ({done, err, rdata, m_enable} !== {4'b0010, 1'b1, 8'h00, 1'b0}) begin fails++; $display("FAIL to_done got done=%b err=%b rdata=%h en=%b want 0010 1 00 0", done, err, rdata, m_enable); end
            end else if (m_enable) begin
                en_cnt++;
            end
        end
        tests++; if (!seen || en_cnt != TOUT) begin fails++; $display("FAIL to_len got seen=%b en_cycles=%0d want 1 %0d", seen, en_cnt, TOUT); end
        req = '0;
        m_stuck = 1'b0;
        tick();
        tests++; if ({err, busy} !== 2'b10) begin fails++; $display("FAIL to_hold got err=%b busy=%b want 1 0", err, busy); end
    endtask

    task automatic test_reset_mid();
        bit hit;
        int dcnt;
        set_client(3, 7'h11, 8'h00, 1'b1);
        req = 4'b1000;
        hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            tick();
            if (busy && !m_enable && gnt != '0 && done == '0) hit = 1'b1;
        end
        tests++; if (!hit) begin fails++; $display("FAIL rm_wait got none want wait_done"); end
        rst = 1'b0;
        tick();
        tests++; if ({gnt, m_enable, busy, done} !== '0) begin fails++; $display("FAIL rm_reset got gnt=%b en=%b busy=%b done=%b want 0", gnt, m_enable, busy, done); end
        rst = 1'b1;
        req = '0;
        dcnt = 0;
        repeat (30) begin tick(); if (done != '0) dcnt++; end
        tests++; if (dcnt != 0) begin fails++; $display("FAIL rm_nodone got %0d want 0", dcnt); end
        for (int i = 0; i < N; i++) set_client(i, 7'(i + 1), 8'(i), 1'b0);
        req = 4'b1111;
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            tick();
            if (gnt != '0) hit = 1'b1;
        end
        tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL rm_first got %b want 0001", gnt); end
        req = '0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            slave_mem[i]  = 8'($urandom);
            slave_nack[i] = 1'b0;
        end
        test_reset();
        test_single_write();
        test_read();
        test_contention();
        test_back_to_back();
        test_nack();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
